slow_decade_countdown: RTL and testbench
========================================

// Module: slow_decade_countdown
// PURPOSE
//  Multi-digit BCD down-counter (countdown timer) paired with the slow decade up-counter.
//  - Decrements one step per cycle in which slowena is high.
//  - Loaded through a valid/ready handshake; started and stopped by command pulses.
//  - Emits a one-cycle done pulse on reaching zero; drives the same digit display path as the up-counter.
// PARAMETERS
//  DIGITS      2   number of BCD digits; q width = 4*DIGITS
// PORTS
//  clk         in   1           rising-edge clock, single clock domain
//  reset_n     in   1           asynchronous, active-low reset
//  slowena     in   1           count-step enable, sampled on clk
//  load_valid  in   1           load request
//  load_value  in   4*DIGITS    BCD preset value, digit 0 in bits [3:0]
//  load_ready  out  1           high only in IDLE; load accepted when load_valid&&load_ready
//  start       in   1           one-cycle command: begin counting
//  stop        in   1           one-cycle command: abort counting, hold q
//  q           out  4*DIGITS    current BCD count
//  busy        out  1           high in RUN
//  done        out  1           one-cycle pulse on terminal count
//  load_err    out  1           one-cycle pulse: load offered with any digit > 9
// BEHAVIOUR
//  - Reset (async assert, sync release): q=0, state=IDLE, busy=0, done=0, load_err=0, reload register=0.
//  - FSM states: IDLE, RUN. All outputs registered; every effect is visible one clock after sampling.
//  - IDLE load:
//      - load_valid with all digits <= 9: q and reload register take load_value.
//      - any digit > 9: value discarded, q unchanged, load_err=1 for one cycle.
//  - IDLE start:
//      - q != 0: go to RUN.
//      - q == 0: ignored; stay IDLE, no done.
//      - load and start in the same cycle: load applies, start is ignored.
//  - RUN, slowena=1: BCD decrement with borrow.
//      - A digit at 0 becomes 9 and borrows from the next digit.
//      - No binary values 10-15 ever appear on any digit.
//  - RUN, terminal step (slowena=1, q==1): q=0, done=1 for one cycle, go to IDLE.
//  - RUN, slowena=0: q holds.
//  - RUN, stop:
//      - Go to IDLE with q held; no done.
//      - stop has priority over a same-cycle slowena; start is ignored in RUN.
//  - IDLE: start and stop in the same cycle → stop wins; stay IDLE.
//  - load_valid in RUN is not accepted (load_ready=0); the requester holds until IDLE.
//  - Reset asserted mid-count: immediate return to reset values; no done.
// CONFIGURATION
//  AUTO_RELOAD_EN defined:
//    - On the terminal step, q takes the reload register, done pulses, and the state stays RUN (periodic timer).
//    - Only stop or reset leave RUN.
//  AUTO_RELOAD_EN undefined:
//    - Terminal step behaves as above: q=0, go to IDLE.
//    - The reload register is still written on load but has no other effect.
// STRUCTURE
//  - Package slow_decade_pkg:
//      - typedef bcd_digit_t (4 bits) and BCD_MAX=4'd9.
//      - State enum cd_state_t {CD_IDLE, CD_RUN}.
//      - Function bcd_valid(digit).
//  - Sub-module bcd_down_digit, instantiated DIGITS times:
//      - Inputs: dec_in, load, load_digit. Outputs: digit, borrow_out (dec_in && digit==0).
//      - Digit i+1 is decremented when digit i borrows.
//  - Top level: FSM, terminal-count detect (q==1), reload register, load validation.
// TESTING
//  - Reset and load:
//      - Reset low mid-RUN → q=00, busy=0, done=0 on the same edge.
//      - Load 8'h25 → load_ready=1, then q=8'h25 next cycle.
//  - Borrow chain:
//      - Load 8'h20, start, one slowena pulse → q=8'h19.
//      - A further 19 slowena pulses → q=8'h00 with done=1 for exactly one cycle; busy falls.
//  - Bad load: load 8'h3A in IDLE → load_err=1 for one cycle, q unchanged, no state change.
//  - Stop priority:
//      - Load 8'h05 and run; stop and slowena in the same cycle → q=8'h05, IDLE, no done.
//      - start with q=00 → stays IDLE.
//  - Gating:
//      - slowena low for 10 cycles in RUN → q constant.
//      - load_valid asserted in RUN → load_ready=0 and q unaffected until IDLE.
//  - AUTO_RELOAD_EN build: load 8'h03, start, continuous slowena → q sequence 02,01,03,02,…
//    with done on every 01→03 step; stop exits to IDLE.

Source files
------------

// File: rtl/slow_decade_pkg.sv
// Shared types and helpers for the slow decade counter family.
package slow_decade_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic {
    CD_IDLE = 1'b0,
    CD_RUN  = 1'b1
  } cd_state_t;

  function automatic logic bcd_valid(input bcd_digit_t digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/slow_decade_countdown_bcd_down_digit.sv
// One BCD down-counting digit; borrow_out feeds the next more-significant digit.
module bcd_down_digit
  import slow_decade_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dec_in,
  input  logic       load,
  input  logic [3:0] load_digit,
  output logic [3:0] digit,
  output logic       borrow_out
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  // Load wins over a same-cycle decrement so an auto-reload lands cleanly.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_digit;
    end else if (dec_in) begin
      digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign borrow_out = dec_in && (digit_q == 4'd0);

endmodule

// File: rtl/slow_decade_countdown.sv
// Multi-digit BCD countdown timer with load handshake and start/stop commands.
// Optional periodic mode: define AUTO_RELOAD_EN to reload on terminal count.
module slow_decade_countdown
  import slow_decade_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  slowena,
  input  logic                  load_valid,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic                  load_ready,
  input  logic                  start,
  input  logic                  stop,
  output logic [4*DIGITS-1:0]   q,
  output logic                  busy,
  output logic                  done,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] COUNT_ONE = W'(1);

  cd_state_t     state_q, state_d;
  logic          done_q, done_d;
  logic          load_err_q, load_err_d;
  logic [W-1:0]  reload_q;
  logic [W-1:0]  count;
  logic [W-1:0]  load_digits;
  logic [DIGITS-1:0] digit_ok;
  logic [DIGITS-1:0] borrow;

  logic is_idle, load_ok, load_accept, load_bad;
  logic step, term_step, digit_load;

  assign is_idle     = (state_q == CD_IDLE);
  assign load_ok     = &digit_ok;
  assign load_accept = is_idle && load_valid && load_ok;
  assign load_bad    = is_idle && load_valid && !load_ok;

  // stop takes priority over a same-cycle count step.
  assign step      = (state_q == CD_RUN) && slowena && !stop;
  assign term_step = step && (count == COUNT_ONE);

`ifdef AUTO_RELOAD_EN
  assign digit_load  = load_accept || term_step;
  assign load_digits = load_accept ? load_value : reload_q;
`else
  logic unused_reload;
  assign digit_load    = load_accept;
  assign load_digits   = load_value;
  assign unused_reload = ^reload_q;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic dec_in;
      if (gi == 0) begin : g_lsd
        assign dec_in = step;
      end else begin : g_upper
        assign dec_in = borrow[gi-1];
      end

      assign digit_ok[gi] = bcd_valid(load_value[4*gi +: 4]);

      bcd_down_digit u_digit (
        .clk        (clk),
        .reset_n    (reset_n),
        .dec_in     (dec_in),
        .load       (digit_load),
        .load_digit (load_digits[4*gi +: 4]),
        .digit      (count[4*gi +: 4]),
        .borrow_out (borrow[gi])
      );
    end
  endgenerate

  logic unused_top_borrow;
  assign unused_top_borrow = borrow[DIGITS-1];

  always_comb begin
    state_d    = state_q;
    done_d     = term_step;
    load_err_d = load_bad;
    case (state_q)
      CD_IDLE: begin
        // Any load offer or stop in the same cycle suppresses start.
        if (start && !stop && !load_valid && (count != '0)) begin
          state_d = CD_RUN;
        end
      end
      CD_RUN: begin
        if (stop) begin
          state_d = CD_IDLE;
        end else if (term_step) begin
`ifdef AUTO_RELOAD_EN
          state_d = CD_RUN;
`else
          state_d = CD_IDLE;
`endif
        end
      end
      default: state_d = CD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CD_IDLE;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      reload_q   <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
      if (load_accept) begin
        reload_q <= load_value;
      end
    end
  end

  assign q          = count;
  assign busy       = (state_q == CD_RUN);
  assign load_ready = is_idle;
  assign done       = done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_slow_decade_countdown.sv
// Directed self-checking bench for slow_decade_countdown (DIGITS=2).
module tb_slow_decade_countdown;

  logic       clk;
  logic       reset_n;
  logic       slowena;
  logic       load_valid;
  logic [7:0] load_value;
  logic       load_ready;
  logic       start;
  logic       stop;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       load_err;

  int errors = 0;
  int checks = 0;

  slow_decade_countdown #(.DIGITS(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .slowena    (slowena),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .start      (start),
    .stop       (stop),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load_valid = 1'b1;
    load_value = v;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    slowena    = 1'b0;
    load_valid = 1'b0;
    load_value = 8'h00;
    start      = 1'b0;
    stop       = 1'b0;
    #12;
    chk("reset_q", q, 8'h00);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_load_err", load_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("idle_load_ready", load_ready, 1);

    // Plain load
    do_load(8'h25);
    chk("load25_q", q, 8'h25);

    // Borrow chain 20 -> 19 -> ... -> 00
    do_load(8'h20);
    chk("load20_q", q, 8'h20);
    do_start();
    chk("start20_busy", busy, 1);
    chk("start20_q", q, 8'h20);
    slowena = 1'b1;
    tick();
    chk("borrow_q19", q, 8'h19);
    for (int i = 0; i < 18; i++) tick();
    chk("before_term_q", q, 8'h01);
    chk("before_term_done", done, 0);
    tick();
    slowena = 1'b0;
    chk("term_q", q, 8'h00);
    chk("term_done", done, 1);
    chk("term_busy", busy, 0);
    tick();
    chk("done_one_cycle", done, 0);
    chk("after_term_q", q, 8'h00);

    // Invalid BCD digit rejected
    do_load(8'h3A);
    chk("badload_err", load_err, 1);
    chk("badload_q", q, 8'h00);
    chk("badload_busy", busy, 0);
    tick();
    chk("badload_err_pulse", load_err, 0);

    // Start with zero count is ignored
    do_start();
    chk("start_zero_busy", busy, 0);
    chk("start_zero_done", done, 0);

    // Stop beats same-cycle slowena
    do_load(8'h05);
    do_start();
    chk("run05_busy", busy, 1);
    stop = 1'b1;
    slowena = 1'b1;
    tick();
    stop = 1'b0;
    slowena = 1'b0;
    chk("stop_q", q, 8'h05);
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);

    // Start and stop together in IDLE: stop wins
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("idle_start_stop_busy", busy, 0);

    // Gating: no slowena, count holds
    do_start();
    chk("gate_busy", busy, 1);
    for (int i = 0; i < 10; i++) tick();
    chk("gate_q_hold", q, 8'h05);

    // Load offered during RUN must wait for IDLE
    load_valid = 1'b1;
    load_value = 8'h42;
    tick();
    chk("run_load_ready", load_ready, 0);
    chk("run_load_q", q, 8'h05);
    slowena = 1'b1;
    tick();
    slowena = 1'b0;
    chk("run_load_dec_q", q, 8'h04);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_then_q", q, 8'h04);
    chk("stop_then_ready", load_ready, 1);
    tick();
    load_valid = 1'b0;
    chk("deferred_load_q", q, 8'h42);

    // Reset asserted mid-count
    do_start();
    slowena = 1'b1;
    tick();
    slowena = 1'b0;
    chk("pre_reset_q", q, 8'h41);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_q", q, 8'h00);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("post_reset_ready", load_ready, 1);

`ifdef AUTO_RELOAD_EN
    do_load(8'h03);
    do_start();
    slowena = 1'b1;
    tick();
    chk("ar_q02", q, 8'h02);
    tick();
    chk("ar_q01", q, 8'h01);
    chk("ar_done0", done, 0);
    tick();
    chk("ar_q03", q, 8'h03);
    chk("ar_done1", done, 1);
    chk("ar_busy", busy, 1);
    tick();
    chk("ar_q02b", q, 8'h02);
    chk("ar_done_pulse", done, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    slowena = 1'b0;
    chk("ar_stop_busy", busy, 0);
    chk("ar_stop_q", q, 8'h02);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
